// File: rtl/note_pitch_detector.sv
// note_pitch_detector
// Recovers the note code played on a 1-bit sigma-delta audio line.
// Flow: 2-flop sync -> windowed ones-count decimator with hysteresis ->
// rising-crossing period counter -> nominal-table match -> confirm FSM.
// NOM_SHIFT scales the nominal table down by a power of two so the same
// detector can run on a proportionally faster tone set; 0 gives the
// standard 12 MHz table.
module note_pitch_detector #(
    parameter int WIN_LOG2  = 6,
    parameter int TH_HI     = 40,
    parameter int TH_LO     = 24,
    parameter int TOL_SHIFT = 6,
    parameter int TIMEOUT   = 100000,
    parameter int CONFIRM   = 2,
    parameter int NOM_SHIFT = 0
) (
    input  logic        clk12,
    input  logic        n_reset,
    input  logic        audio_in,
    output logic [7:0]  note_code,
    output logic        note_valid,
    output logic        locked,
    output logic [16:0] period
);

    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] TH_HI_W   = CW'(TH_HI);
    localparam logic [CW-1:0] TH_LO_W   = CW'(TH_LO);
    localparam logic [16:0]   TMO_W     = 17'(TIMEOUT);
    localparam logic [3:0]    CONFIRM_W = 4'(CONFIRM);

    typedef enum logic [1:0] {
        S_SILENT,
        S_ARMED,
        S_CONFIRMING,
        S_LOCKED
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;

    // Two flops before the asynchronous bitstream is used anywhere.
    always_ff @(posedge clk12 or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= audio_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Decimator with hysteresis
    // ------------------------------------------------------------------
    logic [WIN_LOG2-1:0] r_win_cnt;
    logic [CW-1:0]       r_ones;
    logic                r_level;
    logic [CW-1:0]       w_ones_total;
    logic                w_win_end;
    logic                w_level_nxt;
    logic                w_cross;

    // Total includes the bit arriving in the last cycle of the window.
    assign w_ones_total = r_ones + {{(CW-1){1'b0}}, r_sync2};
    assign w_win_end    = &r_win_cnt;

    // Hysteresis: between the thresholds the previous level is kept.
    always_comb begin
        w_level_nxt = r_level;
        if (w_ones_total >= TH_HI_W)
            w_level_nxt = 1'b1;
        else if (w_ones_total <= TH_LO_W)
            w_level_nxt = 1'b0;
    end

    // Only one rising crossing can be seen per window.
    assign w_cross = w_win_end & ~r_level & w_level_nxt;

    // Count ones per window; update level once at each window end.
    always_ff @(posedge clk12 or negedge n_reset) begin
        if (!n_reset) begin
            r_win_cnt <= '0;
            r_ones    <= '0;
            r_level   <= 1'b0;
        end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
            if (w_win_end) begin
                r_ones  <= '0;
                r_level <= w_level_nxt;
            end else begin
                r_ones  <= w_ones_total;
            end
        end
    end

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    logic [16:0] r_pcnt;
    logic [16:0] r_period;
    logic [16:0] r_cand_period;
    logic        r_cross_d;
    logic        w_tmo;

    // A crossing landing on the timeout cycle wins; timeout is dropped.
    assign w_tmo = (r_pcnt == TMO_W) && !w_cross;

    // Saturating cycle count between crossings; restarts at 1 so the
    // latched value equals the crossing-to-crossing distance.
    always_ff @(posedge clk12 or negedge n_reset) begin
        if (!n_reset) begin
            r_pcnt        <= '0;
            r_period      <= '0;
            r_cand_period <= '0;
            r_cross_d     <= 1'b0;
        end else begin
            r_cross_d <= w_cross;
            if (w_cross) begin
                r_pcnt        <= 17'd1;
                r_period      <= r_pcnt;
                r_cand_period <= r_pcnt;
            end else if (r_pcnt != '1) begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Nominal table match
    // ------------------------------------------------------------------
    function automatic logic [16:0] nominal(input int idx);
        logic [16:0] n;
        case (idx)
            1:       n = 17'd45800;
            2:       n = 17'd40800;
            3:       n = 17'd36400;
            4:       n = 17'd34400;
            5:       n = 17'd30600;
            6:       n = 17'd22900;
            7:       n = 17'd20400;
            8:       n = 17'd18200;
            9:       n = 17'd17200;
            10:      n = 17'd15300;
            default: n = 17'd0;
        endcase
        return n >> NOM_SHIFT;
    endfunction

    function automatic logic within_tol(input logic [16:0] p, input logic [16:0] n);
        logic [16:0] diff;
        diff = (p >= n) ? (p - n) : (n - p);
        return diff <= (n >> TOL_SHIFT);
    endfunction

    logic       w_match_ok;
    logic [3:0] w_match_idx;

    // Scan from the top so the lowest matching index is the one kept.
    always_comb begin
        w_match_ok  = 1'b0;
        w_match_idx = 4'd0;
        for (int i = 10; i >= 1; i--) begin
            if (within_tol(r_cand_period, nominal(i))) begin
                w_match_ok  = 1'b1;
                w_match_idx = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Confirmation FSM (evaluated the cycle after each crossing, when the
    // candidate period register holds the new measurement)
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cand;
    logic [3:0] w_cand_nxt;
    logic [3:0] r_hits;
    logic [3:0] w_hits_nxt;
    logic [3:0] r_note_idx;
    logic [3:0] w_note_nxt;
    logic       r_note_valid;
    logic       w_valid_nxt;

    // State, candidate, hit count and reported note registers.
    always_ff @(posedge clk12 or negedge n_reset) begin
        if (!n_reset) begin
            r_state      <= S_SILENT;
            r_cand       <= '0;
            r_hits       <= '0;
            r_note_idx   <= '0;
            r_note_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_hits       <= w_hits_nxt;
            r_note_idx   <= w_note_nxt;
            r_note_valid <= w_valid_nxt;
        end
    end

    // Next-state logic: timeout forces silence, crossings drive matching.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_hits_nxt  = r_hits;
        w_note_nxt  = r_note_idx;
        w_valid_nxt = 1'b0;
        if (w_tmo) begin
            w_state_nxt = S_SILENT;
            w_hits_nxt  = '0;
            if (r_note_idx != 4'd0) begin
                w_note_nxt  = 4'd0;
                w_valid_nxt = 1'b1;
            end
        end else if (r_cross_d) begin
            case (r_state)
                S_SILENT: begin
                    // First period after silence starts mid-gap; discard it.
                    w_state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (w_match_ok) begin
                        w_state_nxt = S_CONFIRMING;
                        w_cand_nxt  = w_match_idx;
                        w_hits_nxt  = 4'd1;
                    end
                end
                S_CONFIRMING: begin
                    if (!w_match_ok) begin
                        w_state_nxt = S_ARMED;
                        w_hits_nxt  = '0;
                    end else if (w_match_idx == r_cand) begin
                        if ((r_hits + 4'd1) >= CONFIRM_W) begin
                            w_state_nxt = S_LOCKED;
                            w_hits_nxt  = CONFIRM_W;
                            if (r_cand != r_note_idx) begin
                                w_note_nxt  = r_cand;
                                w_valid_nxt = 1'b1;
                            end
                        end else begin
                            w_hits_nxt = r_hits + 4'd1;
                        end
                    end else begin
                        w_cand_nxt = w_match_idx;
                        w_hits_nxt = 4'd1;
                    end
                end
                S_LOCKED: begin
                    // note_code is held here; only a new confirmed note or
                    // a timeout changes it.
                    if (!w_match_ok) begin
                        w_state_nxt = S_ARMED;
                        w_hits_nxt  = '0;
                    end else if (w_match_idx != r_note_idx) begin
                        w_state_nxt = S_CONFIRMING;
                        w_cand_nxt  = w_match_idx;
                        w_hits_nxt  = 4'd1;
                    end
                end
                default: w_state_nxt = S_SILENT;
            endcase
        end
    end

    assign note_code  = {4'h0, r_note_idx};
    assign note_valid = r_note_valid;
    assign locked     = (r_state == S_LOCKED);
    assign period     = r_period;

endmodule
